// File: rtl/riscvx_fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package riscvx_fetch_pkg;

    localparam int          FETCH_DEPTH = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; head word is read straight from storage so a
// pushed entry is visible the cycle after the push.
module fetch_fifo
    import riscvx_fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         clear,
    output logic [WIDTH-1:0]             head_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_wr_ptr;
    logic [PW:0]      r_rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign count     = CW'(r_wr_ptr - r_rd_ptr);
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (count == CW'(DEPTH));
    assign head_data = r_mem[r_rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) r_mem[r_wr_ptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: credit-limited imem requests, PC-tagged instruction queue and
// flush-time discard of wrong-path responses. FETCH_PERF_EN adds perf counters.
module fetch_queue
    import riscvx_fetch_pkg::*;
#(
    parameter int DEPTH   = FETCH_DEPTH,
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [ADDR_W-1:0]  fetch_pc,
    input  logic               j_br,
    output logic               pc_hold,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr,
    input  logic               id_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_dropped,
    output logic [31:0]        perf_starve
`endif
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = ADDR_W + INSTR_W;

    logic [CW-1:0]     w_outst;
    logic [CW-1:0]     w_occ;
    logic [CW-1:0]     r_drop_cnt;
    logic [CW:0]       w_sum;
    logic              w_pend_full;
    logic              w_pend_empty;
    logic              w_q_full;
    logic              w_q_empty;
    logic              w_req_fire;
    logic              w_rsp_drop;
    logic              w_q_push;
    logic              w_q_pop;
    logic [ADDR_W-1:0] w_pend_pc;
    logic [EW-1:0]     w_head;

    // Never issue more than the queue can absorb, so responses need no back-pressure.
    assign w_sum          = {1'b0, w_outst} + {1'b0, w_occ};
    assign imem_req_valid = reset_n && (w_sum < (CW+1)'(DEPTH)) && !w_pend_full;
    assign imem_req_addr  = fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign pc_hold        = !w_req_fire;

    assign w_rsp_drop = j_br || (r_drop_cnt != '0);
    assign w_q_push   = imem_rsp_valid && !w_rsp_drop;
    assign w_q_pop    = if_valid && id_ready && !j_br;

    assign if_valid = !w_q_empty;
    assign if_pc    = if_valid ? w_head[EW-1 -: ADDR_W] : '0;
    assign if_instr = if_valid ? w_head[INSTR_W-1:0]    : '0;

    fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_pend_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_req_fire),
        .push_data (fetch_pc),
        .pop       (imem_rsp_valid),
        .clear     (1'b0),
        .head_data (w_pend_pc),
        .full      (w_pend_full),
        .empty     (w_pend_empty),
        .count     (w_outst)
    );

    fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_instr_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_q_push),
        .push_data ({w_pend_pc, imem_rsp_data}),
        .pop       (w_q_pop),
        .clear     (j_br),
        .head_data (w_head),
        .full      (w_q_full),
        .empty     (w_q_empty),
        .count     (w_occ)
    );

    // On flush every request already in flight is wrong-path; a response arriving
    // in the flush cycle itself is discarded directly, hence the minus one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_cnt <= '0;
        end else if (j_br) begin
            r_drop_cnt <= w_outst - {{(CW-1){1'b0}}, imem_rsp_valid};
        end else if (imem_rsp_valid && (r_drop_cnt != '0)) begin
            r_drop_cnt <= r_drop_cnt - 1'b1;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_dropped;
    logic [31:0] r_perf_starve;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_fetched <= '0;
            r_perf_dropped <= '0;
            r_perf_starve  <= '0;
        end else begin
            if (w_q_push)                     r_perf_fetched <= r_perf_fetched + 1'b1;
            if (imem_rsp_valid && w_rsp_drop) r_perf_dropped <= r_perf_dropped + 1'b1;
            if (!if_valid && id_ready)        r_perf_starve  <= r_perf_starve + 1'b1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_dropped = r_perf_dropped;
    assign perf_starve  = r_perf_starve;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset_n) begin
            assert (!(imem_rsp_valid && w_pend_empty))
                else $error("imem response with no request outstanding");
            assert (w_sum <= (CW+1)'(DEPTH))
                else $error("occupancy plus outstanding exceeds depth");
            assert (!(w_q_full && w_q_push && !w_q_pop))
                else $error("push into full instruction queue");
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: PC-stage and memory models drive the DUT,
// a monitor compares every decoded entry against the expected queue.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int IW    = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] fetch_pc = '0;
    logic          j_br = 1'b0;
    logic          pc_hold;
    logic          imem_req_valid;
    logic [AW-1:0] imem_req_addr;
    logic          imem_req_ready = 1'b0;
    logic          imem_rsp_valid = 1'b0;
    logic [IW-1:0] imem_rsp_data = '0;
    logic          if_valid;
    logic [AW-1:0] if_pc;
    logic [IW-1:0] if_instr;
    logic          id_ready = 1'b0;
`ifdef FETCH_PERF_EN
    logic [31:0]   perf_fetched;
    logic [31:0]   perf_dropped;
    logic [31:0]   perf_starve;
`endif

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .INSTR_W(IW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fetch_pc       (fetch_pc),
        .j_br           (j_br),
        .pc_hold        (pc_hold),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .id_ready       (id_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped),
        .perf_starve    (perf_starve)
`endif
    );

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } mreq_t;

    mreq_t         mq[$];
    logic [63:0]   sb[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            lat = 1;
    int            last_due = 0;
    int            exp_fire = -1;
    int            fires = 0;
    logic          rdy = 1'b0;
    logic          idr = 1'b0;
    logic          flush_req = 1'b0;
    logic [AW-1:0] bta = '0;
    logic [AW-1:0] pc_model = '0;

    function automatic logic [IW-1:0] mem_fn(input logic [AW-1:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive PC stage and memory, then model what fires at the next edge.
    task automatic step();
        logic fire;
        @(negedge clk);
        cyc++;
        j_br           = flush_req;
        fetch_pc       = flush_req ? bta : pc_model;
        flush_req      = 1'b0;
        imem_req_ready = rdy;
        id_ready       = idr;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_fn(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        fire = imem_req_valid && imem_req_ready;
        chk("pc_hold", pc_hold, !fire);
        if (imem_req_valid) chk("req_addr", imem_req_addr, fetch_pc);
        if (exp_fire >= 0) chk("fire", fire, exp_fire);
        if (imem_rsp_valid) void'(mq.pop_front());
        if (j_br) sb.delete();
        if (fire) begin
            fires++;
            last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            mq.push_back('{addr: fetch_pc, due: last_due});
            sb.push_back({fetch_pc, mem_fn(fetch_pc)});
            pc_model = fetch_pc + 4;
        end else if (j_br) begin
            pc_model = bta;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        reset_n        = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        j_br           = 1'b0;
        id_ready       = 1'b0;
        #1;
        chk("rst_if_valid", if_valid, 1'b0);
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_pc_hold", pc_hold, 1'b1);
        chk("rst_if_pc", if_pc, '0);
        chk("rst_if_instr", if_instr, '0);
`ifdef FETCH_PERF_EN
        chk("rst_perf_fetched", perf_fetched, '0);
        chk("rst_perf_dropped", perf_dropped, '0);
        chk("rst_perf_starve", perf_starve, '0);
`endif
        mq.delete();
        sb.delete();
        pc_model  = '0;
        last_due  = 0;
        flush_req = 1'b0;
        rdy       = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Stop issuing and let every outstanding response land and be consumed.
    task automatic drain();
        bit done;
        done = 1'b0;
        rdy  = 1'b0;
        idr  = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (sb.size() == 0 && mq.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_done", done, 1'b1);
        step();
        chk("drained_if_valid", if_valid, 1'b0);
    endtask

    initial begin : monitor
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (reset_n && if_valid && id_ready && !j_br) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_entry: actual pc=%0h instr=%0h required=none", if_pc, if_instr);
                end else begin
                    e = sb.pop_front();
                    chk("if_entry", {if_pc, if_instr}, e);
                    $display("pop pc=%08h instr=%08h", if_pc, if_instr);
                end
            end
        end
    end

    initial begin
        do_reset();

        // Streaming 1-cycle memory: one request accepted every cycle.
        lat = 1; rdy = 1'b1; idr = 1'b1; exp_fire = 1;
        repeat (10) step();
        exp_fire = -1;
        drain();

        // Decode stalled: credit stops issue after DEPTH requests.
        lat = 1; rdy = 1'b1; idr = 1'b0; fires = 0;
        repeat (8) step();
        chk("credit_fires", fires, 4);
        chk("credit_req_valid", imem_req_valid, 1'b0);
        chk("credit_pc_hold", pc_hold, 1'b1);
        idr = 1'b1;
        repeat (8) step();
        drain();

        // Three in flight on a 3-cycle memory, then redirect to 0x100.
        lat = 3; rdy = 1'b1; idr = 1'b1;
        repeat (3) step();
        bta = 32'h100; flush_req = 1'b1;
        step();
        repeat (8) step();
        drain();

        // Flush coinciding with a response while two are outstanding.
        lat = 3; rdy = 1'b1; idr = 1'b1;
        repeat (2) step();
        rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mq.size() > 0 && mq[0].due == cyc + 1) break;
            step();
        end
        bta = 32'h200; flush_req = 1'b1;
        step();
        step();
        chk("post_flush_if_valid", if_valid, 1'b0);
        rdy = 1'b1;
        repeat (6) step();
        drain();

        // Fill the queue, then mix pops with arriving responses.
        lat = 2; rdy = 1'b1; idr = 1'b0;
        repeat (6) step();
        chk("full_req_valid", imem_req_valid, 1'b0);
        for (int i = 0; i < 32; i++) begin
            logic [31:0] pat;
            pat = 32'hB5CC_3A61;
            idr = pat[i];
            step();
        end
        drain();

        // Asynchronous reset in the middle of a stream, then restart from 0.
        lat = 2; rdy = 1'b1; idr = 1'b1;
        repeat (5) step();
        do_reset();
        lat = 1; rdy = 1'b1; idr = 1'b1; exp_fire = 1;
        repeat (6) step();
        exp_fire = -1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
